// File: rtl/bubble_sort_ctrl.sv
// In-place ascending bubble sort of a RAM region, driving a single-port 1-cycle-latency RAM.
// Outputs are decoded from state/registers only; early exit after the first swap-free pass.
module bubble_sort_ctrl #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [ADDR_W:0]       len,
   output logic                  busy,
   output logic                  done,
   output logic [2*ADDR_W-1:0]   swap_cnt,
   output logic [ADDR_W:0]       pass_cnt,
   output logic                  rd,
   output logic                  wr,
   output logic [ADDR_W-1:0]     address,
   output logic [DATA_W-1:0]     data_in,
   input  logic [DATA_W-1:0]     data_out
);

   typedef enum logic [2:0] {
      IDLE, RD_A, RD_B, CMP, WR_A, WR_B, PASS_END, DONE
   } state_t;

   localparam logic [ADDR_W-1:0]   ONE_A = 1;
   localparam logic [ADDR_W:0]     ONE_L = 1;
   localparam logic [2*ADDR_W-1:0] ONE_S = 1;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [ADDR_W:0]     limit_q, limit_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [DATA_W-1:0]   a_reg_q, a_reg_d;
   logic [DATA_W-1:0]   b_reg_q, b_reg_d;
   logic                swapped_q, swapped_d;
   logic [2*ADDR_W-1:0] swap_cnt_q, swap_cnt_d;
   logic [ADDR_W:0]     pass_cnt_q, pass_cnt_d;

   logic [ADDR_W-1:0]   elem_a, elem_b;
   logic                adv;

   // Natural modulo-2^ADDR_W wrap of the adders gives the wrapped region for free.
   assign elem_a = base_q + idx_q;
   assign elem_b = elem_a + ONE_A;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         limit_q    <= '0;
         base_q     <= '0;
         a_reg_q    <= '0;
         b_reg_q    <= '0;
         swapped_q  <= 1'b0;
         swap_cnt_q <= '0;
         pass_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         limit_q    <= limit_d;
         base_q     <= base_d;
         a_reg_q    <= a_reg_d;
         b_reg_q    <= b_reg_d;
         swapped_q  <= swapped_d;
         swap_cnt_q <= swap_cnt_d;
         pass_cnt_q <= pass_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      limit_d    = limit_q;
      base_d     = base_q;
      a_reg_d    = a_reg_q;
      b_reg_d    = b_reg_q;
      swapped_d  = swapped_q;
      swap_cnt_d = swap_cnt_q;
      pass_cnt_d = pass_cnt_q;
      adv        = 1'b0;
      rd         = 1'b0;
      wr         = 1'b0;
      address    = '0;
      data_in    = '0;
      busy       = 1'b0;
      done       = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (len <= ONE_L) begin
                  state_d = DONE;
               end else begin
                  base_d     = base_addr;
                  idx_d      = '0;
                  limit_d    = len - ONE_L;
                  swap_cnt_d = '0;
                  pass_cnt_d = ONE_L;
                  swapped_d  = 1'b0;
                  state_d    = RD_A;
               end
            end
         end
         RD_A: begin
            busy    = 1'b1;
            rd      = 1'b1;
            address = elem_a;
            state_d = RD_B;
         end
         RD_B: begin
            busy    = 1'b1;
            rd      = 1'b1;
            address = elem_b;
            a_reg_d = data_out;
            state_d = CMP;
         end
         CMP: begin
            busy = 1'b1;
            // Strict compare keeps equal words in place, so the sort is stable.
            if (a_reg_q > data_out) begin
               b_reg_d = data_out;
               state_d = WR_A;
            end else begin
               adv = 1'b1;
            end
         end
         WR_A: begin
            busy    = 1'b1;
            wr      = 1'b1;
            address = elem_a;
            data_in = b_reg_q;
            state_d = WR_B;
         end
         WR_B: begin
            busy       = 1'b1;
            wr         = 1'b1;
            address    = elem_b;
            data_in    = a_reg_q;
            swap_cnt_d = swap_cnt_q + ONE_S;
            swapped_d  = 1'b1;
            adv        = 1'b1;
         end
         PASS_END: begin
            busy = 1'b1;
            if (!swapped_q || limit_q == ONE_L) begin
               state_d = DONE;
            end else begin
               limit_d    = limit_q - ONE_L;
               idx_d      = '0;
               swapped_d  = 1'b0;
               pass_cnt_d = pass_cnt_q + ONE_L;
               state_d    = RD_A;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (adv) begin
         if (({1'b0, idx_q} + ONE_L) == limit_q) begin
            state_d = PASS_END;
         end else begin
            idx_d   = idx_q + ONE_A;
            state_d = RD_A;
         end
      end
   end

   assign swap_cnt = swap_cnt_q;
   assign pass_cnt = pass_cnt_q;

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Directed bench for bubble_sort_ctrl with a behavioural 1-cycle-latency RAM.
module tb_bubble_sort_ctrl;
   localparam int DW = 16;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   len = '0;
   logic          busy, done, rd, wr;
   logic [2*AW-1:0] swap_cnt;
   logic [AW:0]   pass_cnt;
   logic [AW-1:0] address;
   logic [DW-1:0] data_in;
   logic [DW-1:0] data_out = '0;

   logic [DW-1:0] mem [1024];
   logic          ld_en = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [DW-1:0] ld_dat = '0;

   int n_err = 0, n_chk = 0;
   int cyc, n_rd, n_wr, n_both, n_done;
   bit saw_wrap, done_seen, aborted;

   bubble_sort_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
      .busy(busy), .done(done), .swap_cnt(swap_cnt), .pass_cnt(pass_cnt),
      .rd(rd), .wr(wr), .address(address), .data_in(data_in), .data_out(data_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ld_en) mem[ld_addr] <= ld_dat;
      else if (wr) mem[address] <= data_in;
      if (rd) data_out <= mem[address];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] v);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = a; ld_dat = v;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_rd"},   32'(rd), 0);
      check({tag, "_wr"},   32'(wr), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_done"}, 32'(done), 0);
      check({tag, "_addr"}, 32'(address), 0);
      check({tag, "_din"},  32'(data_in), 0);
      check({tag, "_swap"}, 32'(swap_cnt), 0);
      check({tag, "_pass"}, 32'(pass_cnt), 0);
   endtask

   // Cycle k is the interval after edge k; start is sampled at edge 0.
   task automatic run(input logic [AW-1:0] b, input logic [AW:0] l,
                      input int restart_at, input bit abort_on_wr);
      logic [AW-1:0] prev_addr;
      bit prev_acc;
      cyc = 0; n_rd = 0; n_wr = 0; n_both = 0; n_done = 0;
      saw_wrap = 0; done_seen = 0; aborted = 0; prev_acc = 0; prev_addr = '0;
      @(negedge clk);
      base_addr = b; len = l; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      while (cyc < 4000) begin
         @(negedge clk);
         cyc++;
         start = (cyc == restart_at);
         if (start) begin base_addr = '0; len = 11'd2; end
         if (rd) n_rd++;
         if (wr) n_wr++;
         if (rd && wr) n_both++;
         if ((rd || wr) && prev_acc && prev_addr == 10'd1023 && address == 10'd0) saw_wrap = 1;
         prev_acc = rd || wr;
         prev_addr = address;
         if (abort_on_wr && wr) begin
            rst_n = 1'b0;
            #1;
            check_outputs_zero("midrst");
            aborted = 1;
            break;
         end
         if (done) begin done_seen = 1; n_done++; break; end
      end
      start = 1'b0;
      check("terminated", 32'(done_seen || aborted), 1);
      if (done_seen) begin
         @(negedge clk);
         check("done_one_cycle", 32'(done), 0);
         check("rd_wr_overlap", 32'(n_both), 0);
      end
   endtask

   initial begin
      int quiet;
      #2;
      check_outputs_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      quiet = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rd || wr || busy) quiet++;
      end
      check("idle_quiet", 32'(quiet), 0);

      // 3,1,2 with a re-pulsed start while busy
      load(10'd0, 16'd3); load(10'd1, 16'd1); load(10'd2, 16'd2);
      run(10'd0, 11'd3, 4, 0);
      check("small_m0", 32'(mem[0]), 1);
      check("small_m1", 32'(mem[1]), 2);
      check("small_m2", 32'(mem[2]), 3);
      check("small_swap", 32'(swap_cnt), 2);
      check("small_pass", 32'(pass_cnt), 2);

      // already sorted, with duplicates
      load(10'd5, 16'd10); load(10'd6, 16'd20); load(10'd7, 16'd20); load(10'd8, 16'd30);
      run(10'd5, 11'd4, -1, 0);
      check("sorted_cycle", 32'(cyc), 11);
      check("sorted_nwr", 32'(n_wr), 0);
      check("sorted_swap", 32'(swap_cnt), 0);
      check("sorted_pass", 32'(pass_cnt), 1);
      check("sorted_m7", 32'(mem[7]), 20);

      // degenerate lengths
      run(10'd100, 11'd0, -1, 0);
      check("len0_cycle", 32'(cyc), 1);
      check("len0_access", 32'(n_rd + n_wr), 0);
      run(10'd100, 11'd1, -1, 0);
      check("len1_cycle", 32'(cyc), 1);
      check("len1_access", 32'(n_rd + n_wr), 0);

      // reverse order across the wrap, aborted by reset in the first WR_A
      for (int i = 0; i < 8; i++) load(10'(1020 + i), 16'(8 - i));
      run(10'd1020, 11'd8, -1, 1);
      check("abort_hit", 32'(aborted), 1);
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_m1020", 32'(mem[1020]), 8);
      check("abort_m1021", 32'(mem[1021]), 7);

      run(10'd1020, 11'd8, -1, 0);
      for (int i = 0; i < 8; i++)
         check($sformatf("rev_m%0d", (1020 + i) % 1024), 32'(mem[(1020 + i) % 1024]), 32'(i + 1));
      check("rev_swap", 32'(swap_cnt), 28);
      check("rev_pass", 32'(pass_cnt), 7);
      check("rev_wrap", 32'(saw_wrap), 1);
      check("rev_ndone", 32'(n_done), 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/bubble_sort_ctrl.md
# bubble_sort_ctrl

In-place ascending bubble-sort engine that drives the single-port 16-bit × 1024-word RAM directly. It occupies the RAM's control port: it issues `rd`, `wr`, `address` and `data_in`, and consumes `data_out`. A host pulses `start` with a base address and an element count. The block then sorts that RAM region as unsigned integers, stops early after the first pass with no swaps, and pulses `done`.

## Interface
- `DATA_W`, 16, word width; matches the RAM.
- `ADDR_W`, 10, RAM address width.
- `clk`  in  1  rising-edge clock shared with the RAM.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  sampled in IDLE only; a 1 latches `base_addr` and `len` and starts a sort.
- `base_addr`  in  ADDR_W  first word of the region.
- `len`  in  ADDR_W+1  element count, 0..1024.
- `busy`  out  1  high from the first RAM access through PASS_END.
- `done`  out  1  one-cycle pulse when the sort completes.
- `swap_cnt`  out  2*ADDR_W  swaps performed in the current or last sort.
- `pass_cnt`  out  ADDR_W+1  passes executed in the current or last sort.
- `rd`  out  1  RAM read strobe.
- `wr`  out  1  RAM write strobe.
- `address`  out  ADDR_W  RAM address.
- `data_in`  out  DATA_W  RAM write data.
- `data_out`  in  DATA_W  RAM read data.

## Operation
- RAM contract:
  - A read issued with `rd=1` and `address=A` at edge k presents `mem[A]` on `data_out` during the cycle after edge k. Read latency is 1.
  - A write with `wr=1` at an edge stores `data_in`.
  - The block never asserts `rd` and `wr` in the same cycle.
- Registers:
  - `idx` is the pair index.
  - `limit` is the number of pairs in the current pass; it starts at `len-1`.
  - `a_reg` holds the first word of the pair.
  - `swapped` records whether any swap occurred in the current pass.
  - `swap_cnt` and `pass_cnt` are the statistics counters.
- Address for element i is `(base_addr + i) mod 2^ADDR_W`. Wrap-around is legal; the wrapped region is sorted normally.
- States:
  - IDLE: outputs quiet. On `start` with `len` ≤ 1, go to DONE. On `start` with `len` ≥ 2: `idx`=0, `limit`=`len-1`, clear `swap_cnt`, set `pass_cnt`=1, clear `swapped`, go to RD_A.
  - RD_A: `rd`=1, `address`=elem(`idx`). Next state RD_B.
  - RD_B: `rd`=1, `address`=elem(`idx+1`). Latch `a_reg`←`data_out`. Next state CMP.
  - CMP: compare `a_reg` with `data_out` (the second word), unsigned.
    - If `a_reg` > `data_out`: latch `b_reg`, go to WR_A.
    - Otherwise: advance.
  - WR_A: `wr`=1, `address`=elem(`idx`), `data_in`=`b_reg`. Next state WR_B.
  - WR_B: `wr`=1, `address`=elem(`idx+1`), `data_in`=`a_reg`. Increment `swap_cnt`, set `swapped`. Then advance.
  - Advance: if `idx+1` == `limit`, go to PASS_END. Otherwise increment `idx` and go to RD_A.
  - PASS_END:
    - If `swapped`=0 or `limit`=1, go to DONE.
    - Otherwise decrement `limit`, set `idx`=0, clear `swapped`, increment `pass_cnt`, go to RD_A.
  - DONE: `done`=1 for one cycle. Next state IDLE.
- Equal words are never swapped, so the sort is stable.
- `start` is ignored outside IDLE, including in the DONE cycle.
- `swap_cnt` and `pass_cnt` hold their values after DONE until the next accepted `start`.

## Timing
- Reset (asynchronous, mid-operation included):
  - State goes to IDLE.
  - `busy`, `done`, `rd`, `wr` = 0.
  - `address`, `data_in`, `swap_cnt`, `pass_cnt` = 0.
  - RAM contents are left as-is: partially sorted, never corrupted by a half-issued swap beyond the word already written.
- All outputs are registered or decoded from state only. There is no combinational path from `data_out` to RAM controls.
- Per-pair cost is 3 cycles without a swap and 5 cycles with a swap. PASS_END costs 1 cycle and DONE costs 1 cycle.
- Cycle numbering: the edge that samples `start` is cycle 0.
  - `len` ≤ 1: `done` in cycle 1; no `rd` or `wr` is ever asserted.
  - Already-sorted `len`=4: RD_A/RD_B/CMP occupy cycles 1–9, PASS_END is cycle 10, `done` is cycle 11.

## Test plan
- Reset check: assert `rst_n`=0 mid-cycle → all outputs are 0 immediately (asynchronous). Release → IDLE; no `rd`/`wr` until `start`.
- Small unsorted region: RAM[0..2] = 3,1,2; `start` with base 0, `len`=3 → RAM = 1,2,3, `swap_cnt`=2, `pass_cnt`=2, `done` pulses exactly once.
- Already-sorted region: RAM[5..8] = 10,20,20,30; `len`=4 → no `wr` ever, `swap_cnt`=0, `pass_cnt`=1, `done` in cycle 11.
- Reverse order with wrap-around: RAM[1020..1023, 0..3] = 8..1; base 1020, `len`=8 → the region reads 1..8, `swap_cnt`=28, `pass_cnt`=7, and addresses wrap 1023→0.
- Degenerate lengths and ignored start: `len`=0 and `len`=1 → `done` in cycle 1 with no RAM access. `start` re-pulsed while `busy`=1 → ignored; `swap_cnt` is unaffected.
- Reset mid-sort: during WR_A of the reverse-order case, pulse `rst_n` low → outputs go to 0. A new `start` re-sorts to the correct 1..8 result.
